// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port BRAM arbiter: FSM state codes,
// port identifiers, access sizes and byte counts.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   localparam logic SZ_BYTE = 1'b0;
   localparam logic SZ_WORD = 1'b1;

   localparam logic [2:0] NB_BYTE = 3'd1;
   localparam logic [2:0] NB_WORD = 3'd4;

   // Number of BRAM byte cycles needed for an access of the given size
   function automatic logic [2:0] nbytes(input logic word);
      return (word == SZ_WORD) ? NB_WORD : NB_BYTE;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb.sv
// Two-input request arbiter. Purely combinational: picks one requester,
// alternating on contention when RR_EN is set, otherwise favouring port A.
// The last-grant history is kept by the parent.
module mem_port_arbiter_rr_arb
   import mem_port_arbiter_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic [1:0] reqs,        // bit 0 = port A, bit 1 = port B
   input  logic       last_grant,  // PORT_A or PORT_B
   output logic [1:0] grant        // one-hot, same bit order as reqs
);

   // One-hot grant; on contention give the port that was not served last
   always_comb begin
      grant = 2'b00;
      case (reqs)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (RR_EN && (last_grant == PORT_A)) ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port 8-bit BRAM (1-cycle registered read) between the CPU
// (port A) and the debug/loader (port B). One transaction at a time; each
// byte or 32-bit word access is broken into big-endian byte cycles.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW    = 16,
   parameter bit RR_EN = 1'b1
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic          a_word,
   input  logic [AW-1:0] a_addr,
   input  logic [31:0]   a_wdata,
   output logic [31:0]   a_rdata,
   output logic          a_done,
   input  logic          b_req,
   input  logic          b_we,
   input  logic          b_word,
   input  logic [AW-1:0] b_addr,
   input  logic [31:0]   b_wdata,
   output logic [31:0]   b_rdata,
   output logic          b_done,
   output logic          busy,
   output logic [AW-1:0] bram_addr,
   output logic          bram_we,
   output logic [7:0]    bram_din,
   input  logic [7:0]    bram_dout
);

   localparam logic [AW-1:0] ADDR_ONE = AW'(1);

   state_t        r_state;
   logic          r_port;
   logic          r_last_grant;
   logic [2:0]    r_cnt;
   logic [2:0]    r_nb;
   logic [23:0]   r_shift;      // read bytes collected so far, MSB first
   logic [23:0]   r_wsh;        // write bytes still to be issued, next in [23:16]

   logic [1:0]    w_reqs;
   logic [1:0]    w_grant;
   logic          w_sel_port;
   logic          w_sel_we;
   logic          w_sel_word;
   logic [AW-1:0] w_sel_addr;
   logic [31:0]   w_sel_wdata;
   logic [2:0]    w_last_idx;

   assign w_reqs     = {b_req, a_req};
   assign w_last_idx = r_nb - 3'd1;

   mem_port_arbiter_rr_arb #(
      .RR_EN (RR_EN)
   ) u_arb (
      .reqs       (w_reqs),
      .last_grant (r_last_grant),
      .grant      (w_grant)
   );

   // Route the winning requester's fields to the acceptance logic
   always_comb begin
      w_sel_port  = w_grant[1] ? PORT_B : PORT_A;
      w_sel_we    = a_we;
      w_sel_word  = a_word;
      w_sel_addr  = a_addr;
      w_sel_wdata = a_wdata;
      if (w_sel_port == PORT_B) begin
         w_sel_we    = b_we;
         w_sel_word  = b_word;
         w_sel_addr  = b_addr;
         w_sel_wdata = b_wdata;
      end
   end

   // Transaction FSM: accept, stream bytes to/from the BRAM, pulse done
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state      <= S_IDLE;
         r_port       <= PORT_A;
         r_last_grant <= PORT_B;
         r_cnt        <= '0;
         r_nb         <= NB_BYTE;
         r_shift      <= '0;
         r_wsh        <= '0;
         busy         <= 1'b0;
         a_done       <= 1'b0;
         b_done       <= 1'b0;
         a_rdata      <= '0;
         b_rdata      <= '0;
         bram_addr    <= '0;
         bram_we      <= 1'b0;
         bram_din     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant != 2'b00) begin
                  r_port       <= w_sel_port;
                  r_last_grant <= w_sel_port;
                  r_nb         <= nbytes(w_sel_word);
                  r_cnt        <= '0;
                  r_shift      <= '0;
                  r_wsh        <= w_sel_wdata[23:0];
                  busy         <= 1'b1;
                  bram_addr    <= w_sel_addr;
                  if (w_sel_we) begin
                     bram_we  <= 1'b1;
                     bram_din <= (w_sel_word == SZ_BYTE) ? w_sel_wdata[7:0]
                                                         : w_sel_wdata[31:24];
                     r_state  <= S_WR;
                  end else begin
                     r_state  <= S_RD;
                  end
               end
            end

            // Addresses go out on the first NB edges; data for each comes
            // back two edges after it was presented, so capture starts at cnt 1.
            S_RD: begin
               r_cnt <= r_cnt + 3'd1;
               if (r_cnt < w_last_idx) begin
                  bram_addr <= bram_addr + ADDR_ONE;
               end
               if (r_cnt != 3'd0) begin
                  r_shift <= {r_shift[15:0], bram_dout};
               end
               if (r_cnt == r_nb) begin
                  if (r_port == PORT_A) begin
                     a_rdata <= {r_shift, bram_dout};
                     a_done  <= 1'b1;
                  end else begin
                     b_rdata <= {r_shift, bram_dout};
                     b_done  <= 1'b1;
                  end
                  r_state <= S_DONE;
               end
            end

            S_WR: begin
               r_cnt <= r_cnt + 3'd1;
               if (r_cnt < w_last_idx) begin
                  bram_addr <= bram_addr + ADDR_ONE;
                  bram_din  <= r_wsh[23:16];
                  r_wsh     <= {r_wsh[15:0], 8'h00};
               end else begin
                  bram_we <= 1'b0;
                  if (r_port == PORT_A) begin
                     a_done <= 1'b1;
                  end else begin
                     b_done <= 1'b1;
                  end
                  r_state <= S_DONE;
               end
            end

            // Done pulse lasts this one cycle; requests are not looked at here
            S_DONE: begin
               a_done  <= 1'b0;
               b_done  <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: BRAM model, scoreboards for done/rdata and
// for BRAM write cycles, plus a fixed-priority instance for arbitration.
module tb_mem_port_arbiter;

   logic        Clk = 1'b0;
   logic        Rst_n;
   always #5 Clk = ~Clk;

   // main DUT (round-robin)
   logic        a_req, a_we, a_word, b_req, b_we, b_word;
   logic [15:0] a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
   logic        a_done, b_done, busy, bram_we;
   logic [15:0] bram_addr;
   logic [7:0]  bram_din, bram_dout;

   // fixed-priority DUT
   logic        a_req0, b_req0, a_done0, b_done0, busy0, bram_we0;
   logic [31:0] a_rdata0, b_rdata0;
   logic [15:0] bram_addr0;
   logic [7:0]  bram_din0;
   logic [7:0]  bram_dout0 = 8'h00;

   mem_port_arbiter #(.AW(16), .RR_EN(1'b1)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .a_req(a_req), .a_we(a_we), .a_word(a_word), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rdata), .a_done(a_done),
      .b_req(b_req), .b_we(b_we), .b_word(b_word), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rdata(b_rdata), .b_done(b_done),
      .busy(busy), .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din),
      .bram_dout(bram_dout)
   );

   mem_port_arbiter #(.AW(16), .RR_EN(1'b0)) dut0 (
      .Clk(Clk), .Rst_n(Rst_n),
      .a_req(a_req0), .a_we(1'b1), .a_word(1'b0), .a_addr(16'h0001), .a_wdata(32'h0000_00AA),
      .a_rdata(a_rdata0), .a_done(a_done0),
      .b_req(b_req0), .b_we(1'b1), .b_word(1'b0), .b_addr(16'h0002), .b_wdata(32'h0000_00BB),
      .b_rdata(b_rdata0), .b_done(b_done0),
      .busy(busy0), .bram_addr(bram_addr0), .bram_we(bram_we0), .bram_din(bram_din0),
      .bram_dout(bram_dout0)
   );

   // BRAM model: write-enable and registered read on posedge
   bit [7:0] mem [0:65535];
   always @(posedge Clk) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      bram_dout <= mem[bram_addr];
   end

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      bit          port;
      bit          rd;
      logic [31:0] rdata;
      int          lat;
      int          start;
   } exp_t;
   typedef struct {
      logic [15:0] addr;
      logic [7:0]  din;
   } wr_t;

   exp_t sb[$];
   wr_t  wq[$];
   bit   q0[$];
   exp_t me;
   wr_t  mw;
   bit   p0;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // done/rdata monitor and BRAM-write monitor for the main DUT
   always @(negedge Clk) begin
      if (a_done || b_done) begin
         check("done_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            me = sb.pop_front();
            check("done_port", {31'b0, b_done}, {31'b0, me.port});
            if (me.rd) check("rdata", b_done ? b_rdata : a_rdata, me.rdata);
            check("done_latency", cyc - me.start, me.lat);
            check("busy_at_done", {31'b0, busy}, 32'd1);
         end
      end
      if (bram_we) begin
         check("write_expected", 32'(wq.size() != 0), 32'd1);
         if (wq.size() != 0) begin
            mw = wq.pop_front();
            check("bram_addr", {16'b0, bram_addr}, {16'b0, mw.addr});
            check("bram_din", {24'b0, bram_din}, {24'b0, mw.din});
         end
      end
   end

   // grant-order monitor for the fixed-priority DUT
   always @(negedge Clk) begin
      if (a_done0 || b_done0) begin
         check("fp_done_expected", 32'(q0.size() != 0), 32'd1);
         if (q0.size() != 0) begin
            p0 = q0.pop_front();
            check("fp_order", {31'b0, b_done0}, {31'b0, p0});
         end
      end
   end

   task automatic drive(input bit p, input bit we, input bit word,
                        input logic [15:0] addr, input logic [31:0] wd);
      if (!p) begin a_we = we; a_word = word; a_addr = addr; a_wdata = wd; end
      else    begin b_we = we; b_word = word; b_addr = addr; b_wdata = wd; end
   endtask

   task automatic push_exp(input bit p, input bit we, input bit word, input logic [15:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int lat);
      exp_t e;
      wr_t  w;
      e.port = p; e.rd = !we; e.rdata = rd; e.lat = lat; e.start = cyc;
      sb.push_back(e);
      if (we) begin
         if (word) begin
            for (int i = 0; i < 4; i++) begin
               w.addr = addr + 16'(i);
               w.din  = wd[31-8*i -: 8];
               wq.push_back(w);
            end
         end else begin
            w.addr = addr; w.din = wd[7:0];
            wq.push_back(w);
         end
      end
   endtask

   // bounded wait for a done pulse: 0=a_done 1=b_done 2=a_done0 3=b_done0
   task automatic wait_sig(input int w);
      bit got = 0;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge Clk);
         case (w)
            0: got = a_done;
            1: got = b_done;
            2: got = a_done0;
            default: got = b_done0;
         endcase
      end
      check("done_wait", {31'b0, got}, 32'd1);
   endtask

   task automatic set_req(input bit p, input bit v);
      if (!p) a_req = v; else b_req = v;
   endtask

   task automatic txn(input bit p, input bit we, input bit word, input logic [15:0] addr,
                      input logic [31:0] wd, input logic [31:0] rd, input int lat);
      @(posedge Clk); #1;
      drive(p, we, word, addr, wd);
      push_exp(p, we, word, addr, wd, rd, lat);
      set_req(p, 1'b1);
      wait_sig(p ? 1 : 0);
      set_req(p, 1'b0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst_n = 1'b0;
      a_req = 0; b_req = 0; a_req0 = 0; b_req0 = 0;
      drive(0, 0, 0, 16'h0, 32'h0);
      drive(1, 0, 0, 16'h0, 32'h0);
      mem[16'h0010] <= 8'hDE; mem[16'h0011] <= 8'hAD;
      mem[16'h0012] <= 8'hBE; mem[16'h0013] <= 8'hEF;
      repeat (3) @(posedge Clk);
      #1;
      check("rst_a_rdata", a_rdata, 32'h0);
      check("rst_b_rdata", b_rdata, 32'h0);
      check("rst_done", {30'b0, a_done, b_done}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_bram_we", {31'b0, bram_we}, 32'h0);
      check("rst_bram_addr", {16'b0, bram_addr}, 32'h0);
      check("rst_bram_din", {24'b0, bram_din}, 32'h0);
      Rst_n = 1'b1;

      // contention from reset: A first, then B
      @(posedge Clk); #1;
      drive(0, 0, 0, 16'h0010, 32'h0);
      drive(1, 0, 0, 16'h0011, 32'h0);
      push_exp(0, 0, 0, 16'h0010, 32'h0, 32'h0000_00DE, 3);
      push_exp(1, 0, 0, 16'h0011, 32'h0, 32'h0000_00AD, 7);
      a_req = 1; b_req = 1;
      wait_sig(0); a_req = 0;
      wait_sig(1); b_req = 0;
      // A alone, then contention again: now B wins first
      txn(0, 0, 0, 16'h0010, 32'h0, 32'h0000_00DE, 3);
      @(posedge Clk); #1;
      drive(0, 0, 0, 16'h0013, 32'h0);
      drive(1, 0, 0, 16'h0012, 32'h0);
      push_exp(1, 0, 0, 16'h0012, 32'h0, 32'h0000_00BE, 3);
      push_exp(0, 0, 0, 16'h0013, 32'h0, 32'h0000_00EF, 7);
      a_req = 1; b_req = 1;
      wait_sig(1); b_req = 0;
      wait_sig(0); a_req = 0;

      // word read
      txn(0, 0, 1, 16'h0010, 32'h0, 32'hDEAD_BEEF, 6);
      // word write by B, rdata of both ports untouched, then byte readback
      txn(1, 1, 1, 16'h0020, 32'h1234_5678, 32'h0, 5);
      check("b_rdata_kept", b_rdata, 32'h0000_00BE);
      check("a_rdata_kept", a_rdata, 32'hDEAD_BEEF);
      txn(0, 0, 0, 16'h0022, 32'h0, 32'h0000_0056, 3);

      // address wrap
      txn(0, 1, 1, 16'hFFFE, 32'hA1B2_C3D4, 32'h0, 5);
      txn(0, 0, 1, 16'hFFFE, 32'h0, 32'hA1B2_C3D4, 6);
      // byte write then byte read
      txn(1, 1, 0, 16'h0050, 32'hFFFF_FF7E, 32'h0, 2);
      txn(1, 0, 0, 16'h0050, 32'h0, 32'h0000_007E, 3);

      // fixed priority: A wins both contentions even after A was last served
      @(posedge Clk); #1;
      q0.push_back(1'b0); q0.push_back(1'b1);
      a_req0 = 1; b_req0 = 1;
      wait_sig(2); a_req0 = 0;
      wait_sig(3); b_req0 = 0;
      @(posedge Clk); #1;
      q0.push_back(1'b0);
      a_req0 = 1;
      wait_sig(2); a_req0 = 0;
      @(posedge Clk); #1;
      q0.push_back(1'b0); q0.push_back(1'b1);
      a_req0 = 1; b_req0 = 1;
      wait_sig(2); a_req0 = 0;
      wait_sig(3); b_req0 = 0;

      // A holds req through done while changing fields
      @(posedge Clk); #1;
      drive(0, 0, 0, 16'h0020, 32'h0);
      push_exp(0, 0, 0, 16'h0020, 32'h0, 32'h0000_0012, 3);
      a_req = 1;
      wait_sig(0);
      drive(0, 0, 0, 16'h0021, 32'h0);
      push_exp(0, 0, 0, 16'h0021, 32'h0, 32'h0000_0034, 4);
      wait_sig(0);
      drive(0, 1, 1, 16'h0030, 32'hCAFE_F00D);
      push_exp(0, 1, 1, 16'h0030, 32'hCAFE_F00D, 32'h0, 6);
      wait_sig(0);
      a_req = 0;
      repeat (4) @(posedge Clk);
      check("rdata_after_write", a_rdata, 32'h0000_0034);

      // reset during a word write after two bytes have been written
      @(posedge Clk); #1;
      drive(0, 1, 1, 16'h0040, 32'h1122_3344);
      wq.push_back('{16'h0040, 8'h11});
      wq.push_back('{16'h0041, 8'h22});
      a_req = 1;
      repeat (3) @(posedge Clk);
      #1;
      Rst_n = 1'b0;
      #1;
      check("abort_bram_we", {31'b0, bram_we}, 32'h0);
      check("abort_busy", {31'b0, busy}, 32'h0);
      check("abort_a_rdata", a_rdata, 32'h0);
      a_req = 0;
      repeat (2) @(posedge Clk);
      #1;
      check("abort_mem40", {24'b0, mem[16'h0040]}, 32'h11);
      check("abort_mem41", {24'b0, mem[16'h0041]}, 32'h22);
      check("abort_mem42", {24'b0, mem[16'h0042]}, 32'h00);
      check("abort_mem43", {24'b0, mem[16'h0043]}, 32'h00);
      Rst_n = 1'b1;
      txn(0, 0, 0, 16'h0041, 32'h0, 32'h0000_0022, 3);

      repeat (4) @(posedge Clk);
      #1;
      check("sb_drained", 32'(sb.size()), 32'd0);
      check("wq_drained", 32'(wq.size()), 32'd0);
      check("q0_drained", 32'(q0.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
